apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master port of `apb_top` between `NUM_REQ` independent requesters. It accepts one request at a time and presents it on the master's `transfer`/`pwrite`/`addr`/`wdata` inputs. It holds the request until `pready`, then returns read data and a completion pulse to the owning requester. It sits directly upstream of `apb_top` in the same `pclk` domain.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT_CYCLES`, 16, wait limit for `m_pready`; used only with `APB_ARB_TIMEOUT_EN`

Ports:
- `pclk`  in  1  clock, rising edge
- `presetn`  in  1  reset; asynchronous assert, active-low
- `req_valid`  in  NUM_REQ  per-requester request level
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened; same slicing
- `req_grant`  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted
- `req_done`  out  NUM_REQ  one-hot, one-cycle pulse when a request completes
- `req_rdata`  out  DATA_WIDTH  read data; valid in the `req_done` cycle of a read
- `req_err`  out  1  high with `req_done` on timeout
- `busy`  out  1  high while a transfer is outstanding
- `m_transfer`, `m_pwrite`  out  1  to `apb_top` `transfer`/`pwrite`
- `m_addr`  out  ADDR_WIDTH  to `apb_top` `addr`
- `m_wdata`  out  DATA_WIDTH  to `apb_top` `wdata`
- `m_prdata`  in  DATA_WIDTH  from `apb_top` `data_out`
- `m_pready`  in  1  from `apb_top` `pready`

## Operation
- FSM states: IDLE, XFER.
- **IDLE, arbitration:** if any `req_valid` is high, select the first set bit, searching from `last+1` upward and wrapping modulo NUM_REQ.
- **IDLE, accept:** register the selected `req_write`, `req_addr` and `req_wdata` into `m_*`, set `m_transfer`, pulse `req_grant[i]`, set `last = i`, then go to XFER.
- **XFER:** `m_*` are held stable and `req_valid` is ignored.
- **Completion:** when `m_pready` is sampled high, clear `m_transfer` and pulse `req_done[i]`. For reads, load `req_rdata` from `m_prdata`. For writes, `req_rdata` keeps its old value. Return to IDLE.
- **Requester contract:** a requester drops `req_valid` the cycle after its grant unless it has a further request. A still-high `req_valid` is treated as a new request at the next IDLE.
- `m_pready` sampled in IDLE is ignored.
- **Reset values:** all outputs 0, state IDLE, `last = NUM_REQ-1` (requester 0 has first priority), timeout counter 0.
- **Reset mid-XFER:** the in-flight transfer is dropped with no `req_done`. After release, arbitration restarts from requester 0.

## Timing
- **Grant latency:** `req_valid` sampled at edge k → `req_grant` and `m_transfer` high in cycle k+1.
- **Completion latency:** `m_pready` sampled at edge m → `req_done` high and `m_transfer` low in cycle m+1.
- A `m_pready` that is already high at the first XFER edge completes in 1 cycle.
- **Back-to-back:** exactly one IDLE cycle separates consecutive transfers, so the minimum period per transfer is 2 cycles plus wait states.
- `busy` equals (state == XFER).

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` counts XFER cycles.
  - When the count reaches TIMEOUT_CYCLES with no `m_pready`: clear `m_transfer`, pulse `req_done[i]` with `req_err = 1`, leave `req_rdata` unchanged, return to IDLE.
  - If `m_pready` arrives in the same cycle the limit is reached, `m_pready` wins and `req_err = 0`.
- **Undefined:** XFER waits indefinitely, `req_err` is tied to 0, and no counter is built.

## Test plan
- **Reset defaults:** assert `presetn=0` mid-XFER → all outputs 0 immediately. After release, `req_valid=4'b1111` → `req_grant=4'b0001` first.
- **Single write:** req 2 writes addr 0x5, wdata 0xA5A5_0001, `m_pready` returns after 3 cycles → `m_pwrite=1`, `m_addr=0x5`. `req_done=4'b0100` one cycle after `m_pready`. `req_rdata` unchanged.
- **Single read:** req 1 reads addr 0x3 with `m_prdata=0xDEAD_BEEF` on the `m_pready` cycle → `req_rdata=0xDEAD_BEEF` together with `req_done=4'b0010`.
- **Round-robin fairness:** all four `req_valid` held high for 8 transfers with `m_pready` tied 1 → grant order 0,1,2,3,0,1,2,3, one transfer per 2 cycles.
- **Hold stability:** change `req_addr`/`req_wdata` of the owner during XFER → `m_addr`/`m_wdata` unchanged until `req_done`.
- **Timeout (`APB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16):** `m_pready` held 0 → `req_done` with `req_err=1` after 16 XFER cycles and the next request is granted. `m_pready` pulsed on cycle 16 → `req_err=0`.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Round-robin arbiter/sequencer sharing one APB master port (apb_top)
// between NUM_REQ requesters. One request is accepted at a time, presented
// on m_*, held until m_pready, then completed with a req_done pulse.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   defined   : a transfer with no m_pready for TIMEOUT_CYCLES XFER cycles
//               completes with req_err = 1
//   undefined : XFER waits indefinitely, req_err is tied to 0
//
// Ports:
//   pclk, presetn             clock (rising edge), async active-low reset
//   req_valid/req_write       per-requester request level and direction
//   req_addr/req_wdata        flattened, requester i at [i*W +: W]
//   req_grant/req_done        one-hot single-cycle pulses
//   req_rdata, req_err        completion data / timeout flag
//   busy                      high while a transfer is outstanding
//   m_transfer/m_pwrite/m_addr/m_wdata   to apb_top
//   m_prdata/m_pready                    from apb_top
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer outstanding; arbitrate and accept one request
// XFER  | m_* held for the owner (last_q) until m_pready or timeout

module apb_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             presetn,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_grant,
   output logic [NUM_REQ-1:0]               req_done,
   output logic [DATA_WIDTH-1:0]            req_rdata,
   output logic                             req_err,
   output logic                             busy,
   output logic                             m_transfer,
   output logic                             m_pwrite,
   output logic [ADDR_WIDTH-1:0]            m_addr,
   output logic [DATA_WIDTH-1:0]            m_wdata,
   input  logic [DATA_WIDTH-1:0]            m_prdata,
   input  logic                             m_pready
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
      $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           last_q, last_d;
   logic                    m_transfer_q, m_transfer_d;
   logic                    m_pwrite_q, m_pwrite_d;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
   logic [NUM_REQ-1:0]      req_grant_q, req_grant_d;
   logic [NUM_REQ-1:0]      req_done_q, req_done_d;
   logic [DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;

   logic                    found;
   logic [IW-1:0]           sel;
   logic                    sel_write;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    tmr_expired;

   // Round-robin search: offsets 1..NUM_REQ from the last owner, so the
   // last owner itself is considered only after everyone else.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (((int'(last_q) + k) % NUM_REQ) == i)) begin
               found = 1'b1;
               sel   = IW'(i);
            end
         end
      end
   end

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          req_err_q, req_err_d;

   // Down-counter loaded at accept; reaching zero at the end of an XFER
   // cycle means TIMEOUT_CYCLES XFER cycles have elapsed.
   assign tmr_expired = (tmr_q == '0);

   always_comb begin
      tmr_d = tmr_q;
      if (state_q == ST_IDLE && found) begin
         tmr_d = TW'(TIMEOUT_CYCLES - 1);
      end else if (state_q == ST_XFER && !tmr_expired) begin
         tmr_d = tmr_q - TW'(1);
      end
   end

   // m_pready has priority over an expiry in the same cycle.
   always_comb begin
      req_err_d = 1'b0;
      if (state_q == ST_XFER && !m_pready && tmr_expired) begin
         req_err_d = 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tmr_q     <= '0;
         req_err_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         req_err_q <= req_err_d;
      end
   end

   assign req_err = req_err_q;
`else
   assign tmr_expired = 1'b0;
   assign req_err     = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      m_transfer_d = m_transfer_q;
      m_pwrite_d   = m_pwrite_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      req_grant_d  = '0;
      req_done_d   = '0;
      req_rdata_d  = req_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d      = ST_XFER;
               last_d       = sel;
               m_transfer_d = 1'b1;
               m_pwrite_d   = sel_write;
               m_addr_d     = sel_addr;
               m_wdata_d    = sel_wdata;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_grant_d[i] = (sel == IW'(i));
               end
            end
         end
         ST_XFER: begin
            if (m_pready || tmr_expired) begin
               state_d      = ST_IDLE;
               m_transfer_d = 1'b0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_done_d[i] = (last_q == IW'(i));
               end
               if (m_pready && !m_pwrite_q) begin
                  req_rdata_d = m_prdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q      <= ST_IDLE;
         last_q       <= IW'(NUM_REQ - 1);
         m_transfer_q <= 1'b0;
         m_pwrite_q   <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         req_grant_q  <= '0;
         req_done_q   <= '0;
         req_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         m_transfer_q <= m_transfer_d;
         m_pwrite_q   <= m_pwrite_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         req_grant_q  <= req_grant_d;
         req_done_q   <= req_done_d;
         req_rdata_q  <= req_rdata_d;
      end
   end

   assign busy       = (state_q == ST_XFER);
   assign m_transfer = m_transfer_q;
   assign m_pwrite   = m_pwrite_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign req_grant  = req_grant_q;
   assign req_done   = req_done_q;
   assign req_rdata  = req_rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic              pclk = 1'b0;
   logic              presetn = 1'b1;
   logic [N-1:0]      req_valid, req_write;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_grant, req_done;
   logic [DW-1:0]     req_rdata;
   logic              req_err, busy, m_transfer, m_pwrite;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata, m_prdata;
   logic              m_pready;

   always #5 pclk = ~pclk;

   apb_req_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_grant(req_grant), .req_done(req_done),
      .req_rdata(req_rdata), .req_err(req_err), .busy(busy),
      .m_transfer(m_transfer), .m_pwrite(m_pwrite),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_prdata(m_prdata), .m_pready(m_pready)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Behavioural model: one outstanding transaction, owner chosen by a
   // modulo search from the previous owner.
   bit            e_busy = 1'b0;
   int            e_last = N - 1;
   int            e_owner = 0;
   int            e_wait = 0;
   int            e_w;
   logic [N-1:0]  e_grant = '0, e_done = '0;
   logic [DW-1:0] e_rdata = '0;
   logic          e_err = 1'b0, e_pwrite = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;

   function automatic int pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   always @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         e_busy = 1'b0; e_last = N - 1; e_wait = 0;
         e_grant = '0; e_done = '0; e_rdata = '0; e_err = 1'b0;
         e_pwrite = 1'b0; e_addr = '0; e_wdata = '0;
      end else begin
         e_grant = '0; e_done = '0; e_err = 1'b0;
         if (!e_busy) begin
            e_w = pick(e_last, req_valid);
            if (e_w >= 0) begin
               e_busy = 1'b1; e_owner = e_w; e_last = e_w; e_wait = 0;
               e_grant[e_w] = 1'b1;
               e_pwrite = req_write[e_w];
               e_addr   = req_addr[e_w*AW +: AW];
               e_wdata  = req_wdata[e_w*DW +: DW];
            end
         end else begin
            e_wait++;
            if (m_pready) begin
               e_busy = 1'b0; e_done[e_owner] = 1'b1;
               if (!e_pwrite) e_rdata = m_prdata;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (e_wait == TO) begin
               e_busy = 1'b0; e_done[e_owner] = 1'b1; e_err = 1'b1;
            end
`endif
         end
      end
   end

   always @(negedge pclk) begin
      if (chk_en) begin
         check("grant", req_grant, e_grant);
         check("done", req_done, e_done);
         check("rdata", req_rdata, e_rdata);
         check("err", req_err, e_err);
         check("busy", busy, e_busy);
         check("m_transfer", m_transfer, e_busy);
         check("m_pwrite", m_pwrite, e_pwrite);
         check("m_addr", m_addr, e_addr);
         check("m_wdata", m_wdata, e_wdata);
      end
   end

   task automatic wait_grant(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge pclk);
         if (req_grant != '0) got = 1'b1;
      end
      check(name, got, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      m_prdata = '0; m_pready = 1'b0;
      #2 presetn = 1'b0;
      chk_en = 1'b1;
      @(negedge pclk);
      @(negedge pclk);
      check("rst_busy", busy, 1'b0);
      check("rst_grant", req_grant, 4'b0000);
      check("rst_transfer", m_transfer, 1'b0);
      check("rst_rdata", req_rdata, 32'h0);
      presetn = 1'b1;

      // round-robin fairness, m_pready tied high
      m_prdata  = 32'h1234_5678;
      m_pready  = 1'b1;
      req_valid = 4'hF;
      req_addr  = {32'h33, 32'h22, 32'h11, 32'h00};
      for (int c = 0; c < 16; c++) begin
         @(negedge pclk);
         check("rr_grant", req_grant, (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000);
      end
      req_valid = '0;
      m_pready  = 1'b0;
      @(negedge pclk);

      // single write from requester 2, m_pready after 3 cycles
      req_valid = 4'b0100; req_write = 4'b0100;
      req_addr[2*AW +: AW]  = 32'h5;
      req_wdata[2*DW +: DW] = 32'hA5A5_0001;
      wait_grant("wr_grant_wait");
      check("wr_grant", req_grant, 4'b0100);
      check("wr_pwrite", m_pwrite, 1'b1);
      check("wr_addr", m_addr, 32'h5);
      check("wr_wdata", m_wdata, 32'hA5A5_0001);
      req_valid = '0;
      repeat (2) @(negedge pclk);
      m_pready = 1'b1;
      @(negedge pclk);
      check("wr_done", req_done, 4'b0100);
      check("wr_rdata_kept", req_rdata, 32'h1234_5678);
      m_pready = 1'b0;

      // single read from requester 1
      req_valid = 4'b0010; req_write = 4'b0000;
      req_addr[1*AW +: AW] = 32'h3;
      wait_grant("rd_grant_wait");
      check("rd_grant", req_grant, 4'b0010);
      check("rd_addr", m_addr, 32'h3);
      req_valid = '0;
      @(negedge pclk);
      m_pready = 1'b1; m_prdata = 32'hDEAD_BEEF;
      @(negedge pclk);
      check("rd_done", req_done, 4'b0010);
      check("rd_rdata", req_rdata, 32'hDEAD_BEEF);
      m_pready = 1'b0; m_prdata = '0;

      // owner changes its request while in XFER
      req_valid = 4'b0001; req_write = 4'b0001;
      req_addr[0 +: AW]  = 32'h40;
      req_wdata[0 +: DW] = 32'h1111_0000;
      wait_grant("hold_grant_wait");
      req_valid = '0;
      req_addr[0 +: AW]  = 32'hFFF;
      req_wdata[0 +: DW] = 32'hBAD;
      repeat (3) begin
         @(negedge pclk);
         check("hold_addr", m_addr, 32'h40);
         check("hold_wdata", m_wdata, 32'h1111_0000);
      end
      m_pready = 1'b1;
      @(negedge pclk);
      check("hold_done", req_done, 4'b0001);
      m_pready = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
      // no m_pready: error completion after TO XFER cycles
      req_valid = 4'b1000; req_write = 4'b0000;
      wait_grant("to_grant_wait");
      req_valid = '0;
      repeat (TO - 1) begin
         @(negedge pclk);
         check("to_no_done", req_done, 4'b0000);
      end
      @(negedge pclk);
      check("to_done", req_done, 4'b1000);
      check("to_err", req_err, 1'b1);
      req_valid = 4'b0001;
      wait_grant("to_next_wait");
      check("to_next_grant", req_grant, 4'b0001);
      req_valid = '0;
      repeat (TO - 1) @(negedge pclk);
      m_pready = 1'b1;
      @(negedge pclk);
      check("to_edge_done", req_done, 4'b0001);
      check("to_edge_err", req_err, 1'b0);
      m_pready = 1'b0;
`endif

      // reset in the middle of a transfer
      req_valid = 4'b1000; req_write = 4'b0000;
      wait_grant("rst_grant_wait");
      req_valid = '0;
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      check("rstx_busy", busy, 1'b0);
      check("rstx_transfer", m_transfer, 1'b0);
      check("rstx_done", req_done, 4'b0000);
      check("rstx_addr", m_addr, 32'h0);
      check("rstx_rdata", req_rdata, 32'h0);
      @(negedge pclk);
      presetn = 1'b1;
      req_valid = 4'hF;
      wait_grant("rstx_grant_wait");
      check("rstx_first_grant", req_grant, 4'b0001);
      req_valid = '0;
      m_pready = 1'b1;
      @(negedge pclk);
      m_pready = 1'b0;

      // randomized traffic against the model
      repeat (3000) begin
         @(negedge pclk);
         if ($urandom_range(0, 299) == 0) begin
            #2 presetn = 1'b0;
            @(negedge pclk);
            presetn = 1'b1;
         end
         req_valid = N'($urandom);
         req_write = N'($urandom);
         for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
         end
         m_pready = ($urandom_range(0, 3) == 0);
         m_prdata = $urandom;
      end
      @(negedge pclk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
